// File: rtl/sink_pkg.sv
// sink_pkg: shared constants, node-ID type and FSM state encoding for the sink lookup block.
package sink_pkg;
  localparam int ID_W = 5;
  localparam int NUM_ENTRIES = 10;
  typedef logic [ID_W-1:0] node_id_t;
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;
endpackage

// File: rtl/sink_req_arbiter.sv
// sink_req_arbiter: 2-input arbiter; round-robin when SINK_LOOKUP_RR_EN is defined, else fixed priority to requester 0.
module sink_req_arbiter (
`ifdef SINK_LOOKUP_RR_EN
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);
`ifdef SINK_LOOKUP_RR_EN
  logic last_q, last_d;
  always_comb begin
    grant = (req[0] && (!req[1] || last_q)) ? 2'b01 : req[1] ? 2'b10 : 2'b00;
    last_d = (en && |req) ? grant[1] : last_q;
  end
  // Reset to "requester 1 granted last" so requester 0 wins the first tie.
  always_ff @(posedge clock or posedge reset)
    if (reset) last_q <= 1'b1;
    else last_q <= last_d;
`else
  always_comb grant = req[0] ? 2'b01 : req[1] ? 2'b10 : 2'b00;
`endif
endmodule

// File: rtl/sink_lookup_ctrl.sv
// sink_lookup_ctrl: arbitrated linear-scan lookup of a node ID in a small known-sink table.
// Arbitration mode selected by SINK_LOOKUP_RR_EN (round-robin when defined, fixed priority otherwise).
module sink_lookup_ctrl
  import sink_pkg::state_e, sink_pkg::IDLE, sink_pkg::SCAN, sink_pkg::DONE;
#(
  parameter int NUM_ENTRIES = sink_pkg::NUM_ENTRIES,
  parameter int ID_W = sink_pkg::ID_W
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            tbl_we,
  input  logic [3:0]      tbl_waddr,
  input  logic [ID_W-1:0] tbl_wdata,
  input  logic [1:0]      req,
  input  logic [ID_W-1:0] req_id0,
  input  logic [ID_W-1:0] req_id1,
  output logic [1:0]      ack,
  output logic            rsp_valid,
  output logic            rsp_owner,
  output logic            rsp_hit,
  output logic [3:0]      rsp_index,
  output logic            busy
);
  localparam logic [3:0] LAST = 4'(NUM_ENTRIES - 1);
  state_e state_q, state_d;
  logic [ID_W-1:0] tbl_id_q [NUM_ENTRIES];
  logic [ID_W-1:0] tbl_id_d [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [3:0] ptr_q, ptr_d, index_q, index_d;
  logic [1:0] ack_q, ack_d, grant;
  logic owner_q, owner_d, rsp_owner_q, rsp_owner_d, hit_q, hit_d;
  logic start, match, scan_end, wr;
  sink_req_arbiter u_arb (
`ifdef SINK_LOOKUP_RR_EN
    .clock (clock),
    .reset (reset),
    .en    (state_q == IDLE),
`endif
    .req   (req),
    .grant (grant)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q     <= IDLE;
      valid_q     <= '0;
      id_q        <= '0;
      ptr_q       <= '0;
      index_q     <= '0;
      ack_q       <= '0;
      owner_q     <= 1'b0;
      rsp_owner_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      id_q        <= id_d;
      ptr_q       <= ptr_d;
      index_q     <= index_d;
      ack_q       <= ack_d;
      owner_q     <= owner_d;
      rsp_owner_q <= rsp_owner_d;
      hit_q       <= hit_d;
    end
  // Table IDs carry no reset; the valid bits alone decide whether an entry can match.
  always_ff @(posedge clock) tbl_id_q <= tbl_id_d;
  always_comb begin
    start    = state_q == IDLE && |req;
    match    = valid_q[ptr_q] && tbl_id_q[ptr_q] == id_q;
    scan_end = state_q == SCAN && (match || ptr_q == LAST);
    wr       = state_q == IDLE && tbl_we && tbl_waddr <= LAST;
    tbl_id_d = tbl_id_q;
    valid_d  = valid_q;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      valid_d[i]  = valid_q[i] | (wr && tbl_waddr == 4'(i));
      tbl_id_d[i] = (wr && tbl_waddr == 4'(i)) ? tbl_wdata : tbl_id_q[i];
    end
    state_d     = state_q == IDLE ? (start ? SCAN : IDLE) :
                  state_q == SCAN ? (scan_end ? DONE : SCAN) : IDLE;
    ack_d       = start ? grant : 2'b00;
    id_d        = start ? (grant[1] ? req_id1 : req_id0) : id_q;
    owner_d     = start ? grant[1] : owner_q;
    ptr_d       = start ? 4'd0 : (state_q == SCAN && !scan_end) ? ptr_q + 4'd1 : ptr_q;
    hit_d       = scan_end ? match : hit_q;
    index_d     = scan_end ? (match ? ptr_q : 4'd0) : index_q;
    rsp_owner_d = scan_end ? owner_q : rsp_owner_q;
  end
  always_comb begin
    busy      = state_q != IDLE;
    rsp_valid = state_q == DONE;
    ack       = ack_q;
    rsp_owner = rsp_owner_q;
    rsp_hit   = hit_q;
    rsp_index = index_q;
  end
endmodule

// File: tb/tb_sink_lookup_ctrl.sv
// tb_sink_lookup_ctrl: directed self-checking bench for sink_lookup_ctrl (expectations follow SINK_LOOKUP_RR_EN).
module tb_sink_lookup_ctrl;
  logic clock = 1'b0, reset = 1'b1, tbl_we = 1'b0;
  logic [3:0] tbl_waddr = '0;
  logic [4:0] tbl_wdata = '0, req_id0 = '0, req_id1 = '0;
  logic [1:0] req = '0;
  logic [1:0] ack;
  logic rsp_valid, rsp_owner, rsp_hit, busy;
  logic [3:0] rsp_index;
  int total = 0, bad = 0;

  sink_lookup_ctrl dut (
    .clock(clock), .reset(reset), .tbl_we(tbl_we), .tbl_waddr(tbl_waddr), .tbl_wdata(tbl_wdata),
    .req(req), .req_id0(req_id0), .req_id1(req_id1), .ack(ack), .rsp_valid(rsp_valid),
    .rsp_owner(rsp_owner), .rsp_hit(rsp_hit), .rsp_index(rsp_index), .busy(busy)
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [4:0] d);
    tbl_we = 1'b1; tbl_waddr = a; tbl_wdata = d;
    tick;
    tbl_we = 1'b0;
  endtask

  // Issues one request, then reports the grant seen, ack-to-rsp_valid latency and the response fields.
  task automatic query(input logic [1:0] r, input logic [4:0] i0, input logic [4:0] i1,
                       output logic [15:0] got);
    int lat;
    logic [1:0] a;
    req = r; req_id0 = i0; req_id1 = i1;
    tick;
    a = ack; req = 2'b00; lat = 0;
    do begin tick; lat++; end while (!rsp_valid && lat < 40);
    got = {a, 8'(lat), rsp_hit, rsp_index, rsp_owner};
    tick;
  endtask

  task automatic test_reset;
    logic [15:0] got;
    reset = 1'b1;
    repeat (3) tick;
    total++;
    if ({ack, rsp_valid, rsp_owner, rsp_hit, rsp_index, busy} !== 10'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %b exp 0", {ack, rsp_valid, rsp_owner, rsp_hit, rsp_index, busy});
    end
    reset = 1'b0;
    tick;
    query(2'b01, 5'd0, 5'd0, got);
    total++;
    if (got !== {2'b01, 8'd10, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL empty_table_id0: got {ack,lat,hit,idx,own}=%h exp %h", got, {2'b01, 8'd10, 1'b0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_lookup;
    logic [15:0] got;
    logic [15:0] exp [5];
    logic [1:0] rq [5];
    logic [4:0] i0 [5], i1 [5];
    for (int i = 0; i < 10; i++) wr(4'(i), 5'(i));
    rq = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b01};
    i0 = '{5'd7, 5'd21, 5'd0, 5'd0, 5'd9};
    i1 = '{5'd0, 5'd0, 5'd3, 5'd0, 5'd0};
    exp = '{{2'b01, 8'd8, 1'b1, 4'd7, 1'b0}, {2'b01, 8'd10, 1'b0, 4'd0, 1'b0},
            {2'b10, 8'd4, 1'b1, 4'd3, 1'b1}, {2'b01, 8'd1, 1'b1, 4'd0, 1'b0},
            {2'b01, 8'd10, 1'b1, 4'd9, 1'b0}};
    for (int v = 0; v < 5; v++) begin
      query(rq[v], i0[v], i1[v], got);
      total++;
      if (got !== exp[v]) begin
        bad++;
        $display("FAIL lookup_%0d: got {ack,lat,hit,idx,own}=%h exp %h", v, got, exp[v]);
      end
    end
    total++;
    if ({ack, rsp_valid, rsp_hit, rsp_index} !== {2'b00, 1'b0, 1'b1, 4'd9}) begin
      bad++;
      $display("FAIL hold_after_done: got {ack,vld,hit,idx}=%b exp 00_0_1_1001", {ack, rsp_valid, rsp_hit, rsp_index});
    end
  endtask

  task automatic test_table_writes;
    logic [15:0] got;
    int lat;
    req = 2'b01; req_id0 = 5'd9;
    tick;
    req = 2'b00;
    wr(4'd3, 5'd17);
    lat = 0;
    while (!rsp_valid && lat < 40) begin tick; lat++; end
    tick;
    query(2'b01, 5'd17, 5'd0, got);
    total++;
    if (got !== {2'b01, 8'd10, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL busy_write_dropped: got %h exp %h", got, {2'b01, 8'd10, 1'b0, 4'd0, 1'b0});
    end
    wr(4'd12, 5'd18);
    query(2'b01, 5'd18, 5'd0, got);
    total++;
    if (got !== {2'b01, 8'd10, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL oob_write_dropped: got %h exp %h", got, {2'b01, 8'd10, 1'b0, 4'd0, 1'b0});
    end
    tbl_we = 1'b1; tbl_waddr = 4'd2; tbl_wdata = 5'd19;
    query(2'b01, 5'd19, 5'd0, got);
    tbl_we = 1'b0;
    total++;
    if (got !== {2'b01, 8'd3, 1'b1, 4'd2, 1'b0}) begin
      bad++;
      $display("FAIL write_at_grant: got %h exp %h", got, {2'b01, 8'd3, 1'b1, 4'd2, 1'b0});
    end
    wr(4'd3, 5'd17);
    query(2'b01, 5'd17, 5'd0, got);
    total++;
    if (got !== {2'b01, 8'd4, 1'b1, 4'd3, 1'b0}) begin
      bad++;
      $display("FAIL idle_write: got %h exp %h", got, {2'b01, 8'd4, 1'b1, 4'd3, 1'b0});
    end
  endtask

  task automatic test_mid_scan_reset;
    logic [15:0] got;
    int seen;
    req = 2'b01; req_id0 = 5'd9;
    tick;
    req = 2'b00;
    repeat (3) tick;
    #2 reset = 1'b1;
    #1;
    total++;
    if ({ack, rsp_valid, rsp_owner, rsp_hit, rsp_index, busy} !== 10'd0) begin
      bad++;
      $display("FAIL mid_scan_reset_outputs: got %b exp 0", {ack, rsp_valid, rsp_owner, rsp_hit, rsp_index, busy});
    end
    @(posedge clock);
    #1 reset = 1'b0;
    seen = 0;
    repeat (15) begin tick; seen += int'(rsp_valid); end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL no_rsp_after_reset: got %0d strobes exp 0", seen);
    end
    query(2'b01, 5'd9, 5'd0, got);
    total++;
    if (got !== {2'b01, 8'd10, 1'b0, 4'd0, 1'b0}) begin
      bad++;
      $display("FAIL valid_cleared: got %h exp %h", got, {2'b01, 8'd10, 1'b0, 4'd0, 1'b0});
    end
  endtask

  task automatic test_arbitration;
    logic [1:0] exp [4];
    int cnt;
`ifdef SINK_LOOKUP_RR_EN
    exp = '{2'b01, 2'b10, 2'b01, 2'b10};
`else
    exp = '{2'b01, 2'b01, 2'b01, 2'b01};
`endif
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
    req = 2'b11; req_id0 = 5'd2; req_id1 = 5'd4;
    for (int g = 0; g < 4; g++) begin
      cnt = 0;
      do begin tick; cnt++; end while (ack == 2'b00 && cnt < 30);
      total++;
      if (ack !== exp[g]) begin
        bad++;
        $display("FAIL arb_grant_%0d: got %b exp %b", g, ack, exp[g]);
      end
    end
    req = 2'b00;
    cnt = 0;
    while (busy && cnt < 30) begin tick; cnt++; end
    tick;
  endtask

  initial begin
    test_reset;
    test_lookup;
    test_table_writes;
    test_mid_scan_reset;
    test_arbitration;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sink_lookup_ctrl.md
SINK_LOOKUP_CTRL -- requirements
Module: sink_lookup_ctrl

Interface
REQ-001 Parameters: NUM_ENTRIES, default 10, number of known-sink table entries; ID_W, default 5, node-ID width.
REQ-002 clock  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 tbl_we  input  1  table write strobe.
REQ-005 tbl_waddr  input  4  table entry index to write.
REQ-006 tbl_wdata  input  ID_W  sink ID to store; the entry's valid bit is set on write.
REQ-007 req  input  2  lookup request, one bit per requester, held until acked.
REQ-008 req_id0, req_id1  input  ID_W  query ID of requester 0 and requester 1.
REQ-009 ack  output  2  one-cycle grant pulse to the accepted requester.
REQ-010 rsp_valid  output  1  one-cycle result strobe.
REQ-011 rsp_owner  output  1  requester the result belongs to.
REQ-012 rsp_hit  output  1  query ID matched a valid entry.
REQ-013 rsp_index  output  4  matching entry index; 0 on miss.
REQ-014 busy  output  1  high in SCAN and DONE.

Function
REQ-015 Three states: IDLE, SCAN, DONE.
REQ-016 IDLE with any req bit high: next edge pulses ack for the winner, latches its ID and owner, sets the scan pointer to 0 and moves to SCAN.
REQ-017 SCAN compares entry[ptr] with the latched ID each cycle and requires a set valid bit.
REQ-018 First match at ptr=k: move to DONE with rsp_hit=1 and rsp_index=k.
REQ-019 No match at ptr=NUM_ENTRIES-1: move to DONE with rsp_hit=0 and rsp_index=0.
REQ-020 Otherwise the pointer increments by 1; it never wraps.
REQ-021 DONE drives rsp_valid=1 for exactly one cycle, then returns to IDLE; rsp_hit, rsp_index and rsp_owner hold until the next DONE.
REQ-022 Latency: ack-to-rsp_valid is k+1 cycles on a hit at entry k, and NUM_ENTRIES cycles on a miss.
REQ-023 The earliest re-grant is the edge after DONE.
REQ-024 A requester still asserting req in the IDLE cycle after its own response is treated as a new request.
REQ-025 Table writes with tbl_we=1 in IDLE, including the same edge as a grant, take effect at that edge.
REQ-026 Table writes while busy=1 are dropped.
REQ-027 Writes with tbl_waddr >= NUM_ENTRIES are dropped.
REQ-028 The arbitration decision is made only in IDLE; req changes while busy do not affect the current scan.
REQ-029 ack is never asserted to a requester whose req bit is low.

Reset
REQ-030 On reset assertion, immediately and including mid-scan: state becomes IDLE, all valid bits clear, and ack, rsp_valid, rsp_owner, rsp_hit, rsp_index and busy become 0.
REQ-031 On reset, the round-robin pointer favours requester 0.
REQ-032 On reset, the in-flight query is discarded and produces no response.
REQ-033 Table ID contents need not be reset.

Configuration
REQ-034 Macro SINK_LOOKUP_RR_EN, defined: round-robin arbitration; on simultaneous requests the requester not granted last wins; the pointer updates on every grant.
REQ-035 SINK_LOOKUP_RR_EN undefined: fixed priority, requester 0 always wins; no pointer register exists.

Structure
REQ-036 A shared package sink_pkg holds the ID_W and NUM_ENTRIES constants, the node-ID typedef and the state enum (IDLE, SCAN, DONE).
REQ-037 One sub-module, sink_req_arbiter, is natural: 2-input arbiter containing the optional round-robin pointer, outputs grant vector.

Verification
REQ-038 Write entries 0..9 with IDs 0..9, then req=01 with req_id0=7: ack=01, then 8 cycles later rsp_valid=1 with rsp_hit=1, rsp_index=7, rsp_owner=0.
REQ-039 Same table, req_id0=21: rsp_valid 10 cycles after ack, rsp_hit=0, rsp_index=0.
REQ-040 req=11 held continuously with SINK_LOOKUP_RR_EN: grants alternate 0,1,0,1; without the macro: grants are 0,0,0.
REQ-041 Write entry 3=5 during SCAN, then query ID 5 afterward: rsp_hit=0 (write was dropped).
REQ-042 Reset asserted at the 4th SCAN cycle: outputs go to 0 immediately, no rsp_valid follows, and all entries read invalid (any query misses).
REQ-043 Table empty after reset, query ID 0: rsp_hit=0, because valid bits gate the match.
